tt_um_count_checker: RTL

Receive-side companion tile for the free-running 8-bit down-counter tile. It samples the counter value arriving on `ui_in`, locks onto the decrement-by-one sequence, and counts sequence errors and wrap-arounds. It reports a selectable result byte on `uo_out`. It occupies its own Tiny Tapeout slot, with `ui_in` wired to the counter tile's `uo_out` and both tiles sharing `clk`.

---
 rtl/count_check_pkg.sv | 26 ++
 rtl/sync2.sv | 33 +++
 rtl/tt_um_count_checker.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/count_check_pkg.sv
// rtl/count_check_pkg.sv - shared state encoding, select codes and match helper for the count checker
//
// Purpose: common definitions used by the checker tile and its bench.
// Contents:
//   state_e     - lock FSM encoding (SEARCH / LOCKING / LOCKED)
//   SEL_*       - output select codes on uio_in[1:0]
//   is_next_down - true when sample is exactly one below prev, modulo 256
package count_check_pkg;

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'b00,
    ST_LOCKING = 2'b01,
    ST_LOCKED  = 2'b10
  } state_e;

  localparam logic [1:0] SEL_ERR    = 2'b00;
  localparam logic [1:0] SEL_PREV   = 2'b01;
  localparam logic [1:0] SEL_STATUS = 2'b10;
  localparam logic [1:0] SEL_WRAP   = 2'b11;

  // 8-bit subtraction wraps, so 0x00 -> 0xFF counts as a valid step.
  function automatic logic is_next_down(input logic [7:0] prev, input logic [7:0] sample);
    return sample == (prev - 8'd1);
  endfunction

endpackage

// File: rtl/sync2.sv
// rtl/sync2.sv - parameterized-width two-flop synchronizer
//
// Purpose: brings an input bus into the clk domain through two flops.
// Ports:
//   clk    in         clock
//   rst_n  in         asynchronous active-low reset, clears both stages
//   i_d    in  WIDTH  raw input
//   o_q    out WIDTH  second-stage (s2) value
module sync2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_s1;
  logic [WIDTH-1:0] r_s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
    end
  end

  assign o_q = r_s2;

endmodule

// File: rtl/tt_um_count_checker.sv
// rtl/tt_um_count_checker.sv - down-counter stream checker with lock FSM, error/wrap counters and result mux
//
// Purpose: locks onto a decrement-by-one byte stream, counts sequence errors
// (saturating) and wrap-arounds, and reports a selectable result byte.
// Ports:
//   ui_in   in  8  counter stream under check
//   uo_out  out 8  registered result byte (err / prev / status / wrap)
//   uio_in  in  8  [1:0] output select, [2] clear (level), [7:3] unused
//   uio_out out 8  constant 0
//   uio_oe  out 8  constant 0 (all uio pins are inputs)
//   ena     in  1  unused
//   clk     in  1  clock
//   rst_n   in  1  asynchronous active-low reset
module tt_um_count_checker
  import count_check_pkg::*;
#(
  parameter int LOCK_COUNT = 4,
  parameter int LOSS_COUNT = 3
) (
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena,
  input  logic       clk,
  input  logic       rst_n
);

  // Comparing the pre-increment count against N-1 is the same as count+1 == N.
  localparam logic [2:0] LOCK_LAST = 3'(LOCK_COUNT - 1);
  localparam logic [2:0] LOSS_LAST = 3'(LOSS_COUNT - 1);

  logic [7:0] w_sample;
  logic [2:0] w_ctrl;
  logic [1:0] w_sel;
  logic       w_clr;
  logic       w_match;
  logic [7:0] w_status;
  logic [7:0] w_mux;

  state_e     r_state;
  logic [7:0] r_prev;
  logic [2:0] r_match_cnt;
  logic [2:0] r_miss_cnt;
  logic [7:0] r_err_cnt;
  logic [7:0] r_wrap_cnt;
  logic       r_lost;
  logic [1:0] r_sel;
  logic [7:0] r_uo_out;

  sync2 #(.WIDTH(8)) u_sync_ui (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (ui_in),
    .o_q   (w_sample)
  );

  sync2 #(.WIDTH(3)) u_sync_ctrl (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (uio_in[2:0]),
    .o_q   (w_ctrl)
  );

  assign w_sel   = w_ctrl[1:0];
  assign w_clr   = w_ctrl[2];
  assign w_match = is_next_down(r_prev, w_sample);

  assign w_status = {(r_state == ST_LOCKED),
                     (r_err_cnt == 8'hFF),
                     r_lost,
                     r_state,
                     (r_state == ST_LOCKED) ? r_miss_cnt : r_match_cnt};

  always_comb begin
    w_mux = r_err_cnt;
    case (r_sel)
      SEL_ERR:    w_mux = r_err_cnt;
      SEL_PREV:   w_mux = r_prev;
      SEL_STATUS: w_mux = w_status;
      SEL_WRAP:   w_mux = r_wrap_cnt;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_SEARCH;
      r_prev      <= '0;
      r_match_cnt <= '0;
      r_miss_cnt  <= '0;
      r_err_cnt   <= '0;
      r_wrap_cnt  <= '0;
      r_lost      <= 1'b0;
      r_sel       <= '0;
      r_uo_out    <= '0;
    end else begin
      r_prev   <= w_sample;
      // The select takes one more flop so it lines up with the counters it
      // picks from: a select change lands on uo_out on the same edge as a
      // sample captured alongside it.
      r_sel    <= w_sel;
      r_uo_out <= w_mux;

      case (r_state)
        ST_SEARCH: begin
          r_match_cnt <= '0;
          r_miss_cnt  <= '0;
          r_state     <= ST_LOCKING;
        end
        ST_LOCKING: begin
          if (w_match) begin
            if (r_match_cnt == LOCK_LAST) begin
              r_state     <= ST_LOCKED;
              r_match_cnt <= '0;
            end else begin
              r_match_cnt <= r_match_cnt + 3'd1;
            end
          end else begin
            r_match_cnt <= '0;
          end
        end
        ST_LOCKED: begin
          if (w_match) begin
            r_miss_cnt <= '0;
            if (w_sample == 8'hFF) begin
              r_wrap_cnt <= r_wrap_cnt + 8'd1;
            end
          end else begin
            if (r_err_cnt != 8'hFF) begin
              r_err_cnt <= r_err_cnt + 8'd1;
            end
            r_miss_cnt <= r_miss_cnt + 3'd1;
            if (r_miss_cnt == LOSS_LAST) begin
              r_state <= ST_SEARCH;
              r_lost  <= 1'b1;
            end
          end
        end
        default: r_state <= ST_SEARCH;
      endcase

      // Placed last so clear overrides any same-cycle increment or set.
      if (w_clr) begin
        r_err_cnt  <= '0;
        r_wrap_cnt <= '0;
        r_lost     <= 1'b0;
      end
    end
  end

  assign uo_out  = r_uo_out;
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

  logic _unused;
  assign _unused = &{ena, uio_in[7:3], 1'b0};

endmodule
